// File: rtl/csa_resolve_seq_pkg.sv
// Shared definitions for the sequential carry-save resolver: FSM encoding,
// default geometry and the counter-width helper.
package csa_resolve_seq_pkg;

  localparam int WIDTH_DEF = 64;
  localparam int CHUNK_DEF = 16;

  // Counter width that stays at least one bit wide even for a single chunk.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int NCHUNK = WIDTH_DEF / CHUNK_DEF;
  localparam int CNT_W  = cnt_width(NCHUNK);

  // 2'd3 is unused and decodes to IDLE behaviour in the top level.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/csa_resolve_seq_cpa_chunk.sv
// One CHUNK-bit slice of the carry-propagate adder, with carry in and carry out.
module cpa_chunk #(
  parameter int CHUNK = 16
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};

endmodule

// File: rtl/csa_resolve_seq.sv
// Resolves a carry-save pair (S, C) into P = S + C, CHUNK bits per cycle,
// with the inter-chunk carry held in a register and valid/ready on both sides.
module csa_resolve_seq
  import csa_resolve_seq_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CHUNK = CHUNK_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] S,
  input  logic [WIDTH-1:0] C,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] P,
  output logic             COUT
);

  localparam int N_CHUNK = WIDTH / CHUNK;
  localparam int N_CNT_W = cnt_width(N_CHUNK);
  localparam logic [N_CNT_W-1:0] LAST = N_CNT_W'(N_CHUNK - 1);

  state_t               state_q, state_d;
  logic [N_CNT_W-1:0]   cnt_q;
  logic                 carry_q;
  logic [WIDTH-1:0]     s_q, c_q, p_q;
  logic                 cout_q;
  logic                 load, step;
  logic [CHUNK-1:0]     chunk_sum;
  logic                 chunk_cout;

  cpa_chunk #(.CHUNK(CHUNK)) u_chunk (
    .a    (s_q[cnt_q*CHUNK +: CHUNK]),
    .b    (c_q[cnt_q*CHUNK +: CHUNK]),
    .cin  (carry_q),
    .sum  (chunk_sum),
    .cout (chunk_cout)
  );

  // NOTE: every signal written here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    load      = 1'b0;
    step      = 1'b0;
    case (state_q)
      BUSY: begin
        step = 1'b1;
        if (cnt_q == LAST) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        // Accepting while the result leaves keeps back-to-back ops bubble-free.
        in_ready  = out_ready;
        if (out_ready) begin
          if (in_valid) begin
            load    = 1'b1;
            state_d = BUSY;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        in_ready = 1'b1;
        if (in_valid) begin
          load    = 1'b1;
          state_d = BUSY;
        end
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      // NOTE: the operand holding registers are reset as well, so an
      // abandoned operation leaves no stale operands behind.
      s_q     <= '0;
      c_q     <= '0;
      p_q     <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load) begin
        s_q     <= S;
        c_q     <= C;
        cnt_q   <= '0;
        carry_q <= 1'b0;
      end else if (step) begin
        p_q[cnt_q*CHUNK +: CHUNK] <= chunk_sum;
        carry_q <= chunk_cout;
        if (cnt_q == LAST) begin
          cnt_q  <= '0;
          cout_q <= chunk_cout;
        end else begin
          cnt_q  <= cnt_q + 1'b1;
        end
      end
    end
  end

  assign P    = p_q;
  assign COUT = cout_q;

endmodule

// File: tb/tb_csa_resolve_seq.sv
// Self-checking bench for csa_resolve_seq: directed corner cases plus a
// randomized valid/ready stream scored against plain 65-bit addition.
module tb_csa_resolve_seq;

  localparam int NRAND = 4000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] s, c;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] p;
  logic        cout;

  int errors = 0;
  int checks = 0;

  csa_resolve_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .S         (s),
    .C         (c),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .P         (p),
    .COUT      (cout)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [64:0] got, input logic [64:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h want=%h", tag, got, exp);
    end
  endtask

  // Called at a negedge; presents one pair and returns at the negedge after acceptance.
  task automatic send(input logic [63:0] sv, input logic [63:0] cv, input string tag);
    in_valid = 1'b1;
    s = sv;
    c = cv;
    #1 check({tag, "_in_ready"}, 65'(in_ready), 65'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Counts negedges until out_valid, starting at the negedge just after acceptance.
  task automatic wait_result(output int lat);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    if (!out_valid) check("result_timeout", 65'd0, 65'd1);
  endtask

  task automatic take();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    int          lat;
    logic        bad;
    logic [63:0] sum_exp;
    logic [64:0] q[$];
    logic [64:0] e;
    int          sent, got, cyc;
    logic        acc;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; s = '0; c = '0;
    repeat (3) @(negedge clk);
    check("rst_out_valid", 65'(out_valid), 65'd0);
    check("rst_in_ready",  65'(in_ready),  65'd1);
    check("rst_p",         65'(p),         65'd0);
    check("rst_cout",      65'(cout),      65'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // T1: all ones plus one wraps to zero with carry out, latency NCHUNK.
    send(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, "t1");
    wait_result(lat);
    check("t1_latency", 65'(lat), 65'd4);
    check("t1_p",    65'(p),    65'd0);
    check("t1_cout", 65'(cout), 65'd1);
    take();

    // T2: carry crosses the first chunk boundary only.
    send(64'h0000_0000_0000_FFFF, 64'h1, "t2");
    wait_result(lat);
    check("t2_p",    65'(p),    65'h0000_0000_0001_0000);
    check("t2_cout", 65'(cout), 65'd0);
    take();

    // T4: a pair held on the input during BUSY must not be sampled.
    send(64'h1234_5678, 64'h1111, "t4");
    in_valid = 1'b1; s = 64'hDEAD; c = 64'h0;
    bad = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      if (in_ready) bad = 1'b1;
      @(negedge clk);
      lat++;
    end
    check("t4_ready_in_busy", 65'(bad), 65'd0);
    check("t4_valid", 65'(out_valid), 65'd1);
    check("t4_p", 65'(p), 65'(64'h1234_5678 + 64'h1111));
    in_valid = 1'b0;
    take();
    check("t4_idle_after", 65'(out_valid), 65'd0);

    // T3: backpressure holds the result, then a same-cycle hand-over.
    send(64'd123, 64'd456, "t3");
    wait_result(lat);
    bad = 1'b0;
    repeat (10) begin
      if (p !== 64'd579 || cout !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b1) bad = 1'b1;
      @(negedge clk);
    end
    check("t3_hold_stable", 65'(bad), 65'd0);
    out_ready = 1'b1; in_valid = 1'b1; s = 64'd5; c = 64'd7;
    #1 check("t3_handover_ready", 65'(in_ready), 65'd1);
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b0;
    check("t3_busy_after", 65'(out_valid), 65'd0);
    wait_result(lat);
    check("t3_latency", 65'(lat), 65'd4);
    check("t3_p",    65'(p),    65'd12);
    check("t3_cout", 65'(cout), 65'd0);
    take();

    // T5: reset on the second BUSY cycle abandons the operation.
    send(64'hFFFF_0000_FFFF_0000, 64'h0001_FFFF_0001_FFFF, "t5");
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("t5_out_valid", 65'(out_valid), 65'd0);
    check("t5_p",         65'(p),         65'd0);
    check("t5_cout",      65'(cout),      65'd0);
    check("t5_in_ready",  65'(in_ready),  65'd1);
    rst_n = 1'b1;
    bad = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid) bad = 1'b1;
    end
    check("t5_no_spurious", 65'(bad), 65'd0);

    // T6: random stream with random valid/ready against plain addition.
    sent = 0; got = 0; cyc = 0; acc = 1'b0;
    while ((sent < NRAND || q.size() != 0) && cyc < 60000) begin
      if (!in_valid && sent < NRAND && ($urandom % 4) != 0) begin
        s = {$urandom, $urandom};
        case ($urandom_range(0, 3))
          0: c = ~s;
          1: c = ~s + 64'd1;
          default: c = {$urandom, $urandom};
        endcase
        in_valid = 1'b1;
      end
      out_ready = ($urandom % 3) != 0;
      #1;
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          check("rand_spurious", 65'd1, 65'd0);
        end else begin
          e = q.pop_front();
          check("rand_p",    65'(p),    65'(e[63:0]));
          check("rand_cout", 65'(cout), 65'(e[64]));
          got++;
        end
      end
      acc = in_valid && in_ready;
      if (acc) begin
        sum_exp = s + c;
        q.push_back({1'b0, s} + {1'b0, c});
        sent++;
      end
      @(negedge clk);
      if (acc) in_valid = 1'b0;
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    check("rand_sent", 65'(sent), 65'(NRAND));
    check("rand_got",  65'(got),  65'(NRAND));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
